// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit-FIFO launch states and default widths.
package uart_pkg;

    localparam int UART_DATA_W        = 8;
    localparam int UART_TXF_DEPTH_DEF = 16;

    typedef enum logic [1:0] {
        TXF_IDLE  = 2'd0,
        TXF_START = 2'd1,
        TXF_DRAIN = 2'd2
    } txf_state_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// Simple dual-port register array: clocked write port, combinational read port.
// Contents are deliberately not reset; validity is tracked by the owner's pointers.
module uart_fifo_ram
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int DEPTH  = UART_TXF_DEPTH_DEF,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO in front of uart_tx, drained via a tx_start/tx_busy level handshake.
// Optional: define UART_TX_FIFO_DROP_CNT_EN to add a saturating drop_count output.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int DEPTH  = UART_TXF_DEPTH_DEF,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       level,
    output logic              overflow,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data
`ifdef UART_TX_FIFO_DROP_CNT_EN
    ,
    output logic [7:0]        drop_count
`endif
);

    localparam logic [AW:0] PTR_INC = (AW+1)'(1);

    txf_state_t        r_state;
    txf_state_t        w_state_nxt;
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [DATA_W-1:0] r_tx_data;
    logic [DATA_W-1:0] w_head;
    logic              r_overflow;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_reject;
    logic              w_tx_start;

    // Extra pointer MSB separates full (same slot, other lap) from empty.
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_pop    = (r_state == TXF_IDLE) && !w_empty && !tx_busy;
    assign w_push   = wr_en && (!w_full || w_pop);
    assign w_reject = wr_en && !w_push;

    uart_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (wr_data),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_head)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= TXF_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_tx_data  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_overflow <= w_reject;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_INC;
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + PTR_INC;
                r_tx_data <= w_head;
            end
        end
    end

    // START holds tx_start until uart_tx acknowledges with tx_busy.
    always_comb begin
        w_state_nxt = r_state;
        w_tx_start  = 1'b0;
        case (r_state)
            TXF_IDLE: begin
                if (w_pop) w_state_nxt = TXF_START;
            end
            TXF_START: begin
                w_tx_start = 1'b1;
                if (tx_busy) w_state_nxt = TXF_DRAIN;
            end
            TXF_DRAIN: begin
                if (!tx_busy) w_state_nxt = TXF_IDLE;
            end
            default: w_state_nxt = TXF_IDLE;
        endcase
    end

    assign full     = w_full;
    assign empty    = w_empty;
    assign level    = r_wr_ptr - r_rd_ptr;
    assign overflow = r_overflow;
    assign tx_start = w_tx_start;
    assign tx_data  = r_tx_data;

`ifdef UART_TX_FIFO_DROP_CNT_EN
    logic [7:0] r_drop_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_count <= '0;
        end else if (w_reject && (r_drop_count != 8'hFF)) begin
            r_drop_count <= r_drop_count + 8'd1;
        end
    end

    assign drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus randomized fill/drain
// against a queue model and a behavioural uart_tx that latches start on baud ticks.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int BAUD   = 4;          // short bit time keeps full drains brief
    localparam int FRAME  = 10 * BAUD;

    logic              clk      = 1'b0;
    logic              reset    = 1'b1;
    logic              wr_en    = 1'b0;
    logic [DATA_W-1:0] wr_data  = '0;
    logic              full;
    logic              empty;
    logic [4:0]        level;
    logic              overflow;
    logic              tx_busy;
    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
`ifdef UART_TX_FIFO_DROP_CNT_EN
    logic [7:0]        drop_count;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    logic       model_en = 1'b0;
    logic       busy_man = 1'b1;
    logic       m_busy   = 1'b0;
    int         m_cnt    = 0;
    int         m_baud   = 0;
    logic [7:0] rxq  [$];
    logic [7:0] expq [$];

    assign tx_busy = model_en ? m_busy : busy_man;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow),
        .tx_busy  (tx_busy),
        .tx_start (tx_start),
        .tx_data  (tx_data)
`ifdef UART_TX_FIFO_DROP_CNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    // Behavioural uart_tx: accepts a start only on a baud tick, busy for one frame.
    always @(negedge clk) begin
        if (reset || !model_en) begin
            m_busy = 1'b0;
            m_cnt  = 0;
            m_baud = 0;
        end else begin
            m_baud = (m_baud == BAUD - 1) ? 0 : m_baud + 1;
            if (m_busy) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) m_busy = 1'b0;
            end else if (m_baud == 0 && tx_start) begin
                rxq.push_back(tx_data);
                m_busy = 1'b1;
                m_cnt  = FRAME;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        wr_en    = 1'b0;
        wr_data  = '0;
        model_en = 1'b0;
        busy_man = 1'b1;
        reset    = 1'b1;
        step();
        step();
        reset = 1'b0;
        rxq.delete();
        expq.delete();
        step();
    endtask

    task automatic push_hold(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        step();
        wr_en   = 1'b0;
        expq.push_back(b);
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        int c;
        c = 0;
        while (rxq.size() < n && c < budget) begin
            step();
            c++;
        end
        ok = (rxq.size() >= n);
    endtask

    task automatic test_reset();
        busy_man = 1'b1;
        reset    = 1'b1;
        step();
        step();
        n_cmp++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
        n_cmp++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
        n_cmp++; if (level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
`ifdef UART_TX_FIFO_DROP_CNT_EN
        n_cmp++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL reset_drop_count: got %0d want 0", drop_count); end
`endif
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_launch();
        do_reset();
        busy_man = 1'b0;
        push_hold(8'h41);
        n_cmp++; if (level !== 5'd1) begin n_fail++; $display("FAIL launch_level_after_push: got %0d want 1", level); end
        n_cmp++; if (empty !== 1'b0) begin n_fail++; $display("FAIL launch_empty_after_push: got %b want 0", empty); end
        n_cmp++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL launch_start_early: got %b want 0", tx_start); end
        step();
        n_cmp++; if (level !== 5'd0) begin n_fail++; $display("FAIL launch_level_after_pop: got %0d want 0", level); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (tx_start !== 1'b1) begin n_fail++; $display("FAIL launch_start_hold[%0d]: got %b want 1", i, tx_start); end
            n_cmp++; if (tx_data !== 8'h41) begin n_fail++; $display("FAIL launch_data_hold[%0d]: got %h want 41", i, tx_data); end
            if (i < 3) step();
        end
        busy_man = 1'b1;
        step();
        n_cmp++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL launch_start_drop: got %b want 0", tx_start); end
        n_cmp++; if (level !== 5'd0) begin n_fail++; $display("FAIL launch_level_drain: got %0d want 0", level); end
        busy_man = 1'b0;
        step();
        step();
        step();
        n_cmp++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL launch_no_restart: got %b want 0", tx_start); end
    endtask

    task automatic test_drain();
        bit ok;
        int n;
        logic [7:0] got;
        n = expq.size();
        rxq.delete();
        model_en = 1'b1;
        wait_rx(n, n * (FRAME + 2 * BAUD + 8) + 50, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL drain_timeout: got %0d frames want %0d", rxq.size(), n); end
        for (int i = 0; i < n; i++) begin
            got = (i < rxq.size()) ? rxq[i] : 8'hxx;
            n_cmp++; if (got !== expq[i]) begin n_fail++; $display("FAIL drain_byte[%0d]: got %h want %h", i, got, expq[i]); end
        end
        repeat (FRAME + 3 * BAUD + 10) step();
        n_cmp++; if (rxq.size() != n) begin n_fail++; $display("FAIL drain_extra_frames: got %0d want %0d", rxq.size(), n); end
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b want 1", empty); end
        n_cmp++; if (level !== 5'd0) begin n_fail++; $display("FAIL drain_level: got %0d want 0", level); end
        model_en = 1'b0;
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int i = 1; i <= DEPTH; i++) begin
            push_hold(8'(i));
            n_cmp++; if (level !== 5'(i)) begin n_fail++; $display("FAIL fill_level[%0d]: got %0d want %0d", i, level, i); end
        end
        n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b want 1", full); end
        wr_en   = 1'b1;
        wr_data = 8'hFF;
        step();
        wr_en = 1'b0;
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fill_overflow_pulse: got %b want 1", overflow); end
        n_cmp++; if (level !== 5'd16) begin n_fail++; $display("FAIL fill_level_after_reject: got %0d want 16", level); end
        step();
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_overflow_single: got %b want 0", overflow); end
`ifdef UART_TX_FIFO_DROP_CNT_EN
        n_cmp++; if (drop_count !== 8'd1) begin n_fail++; $display("FAIL fill_drop_count: got %0d want 1", drop_count); end
`endif
        test_drain();
    endtask

    task automatic test_back_to_back_push_pop();
        do_reset();
        for (int i = 0; i < DEPTH; i++) push_hold(8'($urandom));
        busy_man = 1'b0;
        wr_en    = 1'b1;
        wr_data  = 8'h99;
        step();
        wr_en = 1'b0;
        expq.push_back(8'h99);
        n_cmp++; if (level !== 5'd16) begin n_fail++; $display("FAIL pp_level: got %0d want 16", level); end
        n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL pp_full: got %b want 1", full); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL pp_overflow: got %b want 0", overflow); end
        n_cmp++; if (tx_start !== 1'b1) begin n_fail++; $display("FAIL pp_start: got %b want 1", tx_start); end
        n_cmp++; if (tx_data !== expq[0]) begin n_fail++; $display("FAIL pp_data: got %h want %h", tx_data, expq[0]); end
        test_drain();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 6; i++) push_hold(8'($urandom));
        busy_man = 1'b0;
        step();
        n_cmp++; if (tx_start !== 1'b1) begin n_fail++; $display("FAIL rmid_start: got %b want 1", tx_start); end
        n_cmp++; if (level !== 5'd5) begin n_fail++; $display("FAIL rmid_level_before: got %0d want 5", level); end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL rmid_start_async: got %b want 0", tx_start); end
        n_cmp++; if (level !== 5'd0) begin n_fail++; $display("FAIL rmid_level_async: got %0d want 0", level); end
        step();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL rmid_spurious[%0d]: got %b want 0", i, tx_start); end
            n_cmp++; if (level !== 5'd0) begin n_fail++; $display("FAIL rmid_level[%0d]: got %0d want 0", i, level); end
        end
    endtask

    task automatic test_overflow_burst();
        int ov;
        int bad;
        ov  = 0;
        bad = 0;
        do_reset();
        for (int i = 0; i < DEPTH; i++) push_hold(8'($urandom));
        wr_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            wr_data = 8'($urandom);
            step();
            if (overflow === 1'b1) ov++;
            if (level !== 5'd16) bad++;
        end
        wr_en = 1'b0;
        step();
        n_cmp++; if (ov != 300) begin n_fail++; $display("FAIL burst_overflow_cycles: got %0d want 300", ov); end
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL burst_level_changed: got %0d cycles want 0", bad); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL burst_overflow_end: got %b want 0", overflow); end
`ifdef UART_TX_FIFO_DROP_CNT_EN
        n_cmp++; if (drop_count !== 8'd255) begin n_fail++; $display("FAIL burst_drop_sat: got %0d want 255", drop_count); end
`endif
        test_drain();
    endtask

    task automatic test_random_fill();
        logic exp_ov;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            wr_en   = ($urandom_range(0, 9) < 7);
            wr_data = 8'($urandom);
            exp_ov  = 1'b0;
            if (wr_en) begin
                if (expq.size() < DEPTH) expq.push_back(wr_data);
                else exp_ov = 1'b1;
            end
            step();
            n_cmp++; if (level !== 5'(expq.size())) begin n_fail++; $display("FAIL rnd_level[%0d]: got %0d want %0d", i, level, expq.size()); end
            n_cmp++; if (full !== (expq.size() == DEPTH)) begin n_fail++; $display("FAIL rnd_full[%0d]: got %b want %b", i, full, expq.size() == DEPTH); end
            n_cmp++; if (empty !== (expq.size() == 0)) begin n_fail++; $display("FAIL rnd_empty[%0d]: got %b want %b", i, empty, expq.size() == 0); end
            n_cmp++; if (overflow !== exp_ov) begin n_fail++; $display("FAIL rnd_overflow[%0d]: got %b want %b", i, overflow, exp_ov); end
        end
        wr_en = 1'b0;
        test_drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_launch();
        test_fill_overflow();
        test_back_to_back_push_pop();
        test_reset_mid();
        test_overflow_burst();
        test_random_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
